// File: rtl/roce_gen_pkg.sv
// Shared definitions for the RoCE payload generator.
//   gen_state_e : generator FSM states
//   LFSR_TAPS   : feedback taps of the 32-bit pattern LFSR (taps 32,22,2,1)
//   lfsr_step   : one shift of the Fibonacci LFSR (feedback enters at bit 0)
package roce_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_GAP     = 2'd3
   } gen_state_e;

   // Bit n-1 set for tap n.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/roce_lfsr32.sv
// 32-bit pattern LFSR.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset, loads SEED
//   en_i    : advance one step at the next edge
//   state_o : current LFSR state
module roce_lfsr32
   import roce_gen_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_2468
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= SEED;
      end else if (en_i) begin
         state_q <= lfsr_step(state_q);
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/roce_payload_gen.sv
// RoCE payload generator: emits a BTH header handshake followed by an
// AXI-Stream payload per frame, with programmable length, frame count,
// inter-frame gap and a graceful stop.
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   start, stop            : run start pulse, graceful stop request
//   cfg_*                  : run configuration, latched on start
//   m_roce_bth_*           : header channel (valid/ready + fields)
//   m_axis_*               : payload stream (tuser tied low)
//   busy, done, frames_sent: run status
module roce_payload_gen
   import roce_gen_pkg::*;
#(
   parameter int          DATA_WIDTH = 64,
   parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
   parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  stop,
   input  logic [15:0]           cfg_payload_len,
   input  logic [31:0]           cfg_frame_count,
   input  logic [7:0]            cfg_gap_cycles,
   input  logic [7:0]            cfg_op_code,
   input  logic [23:0]           cfg_psn_start,
   input  logic [23:0]           cfg_dest_qp,
   output logic                  m_roce_bth_valid,
   input  logic                  m_roce_bth_ready,
   output logic [7:0]            m_roce_bth_op_code,
   output logic [23:0]           m_roce_bth_psn,
   output logic [23:0]           m_roce_bth_dest_qp,
   output logic                  m_roce_bth_ack_req,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           frames_sent
);

   localparam int KW_LOG2 = $clog2(KEEP_WIDTH);
   localparam int LANES   = DATA_WIDTH / 32;

   gen_state_e            state_q;
   logic [15:0]           len_q;
   logic [31:0]           count_q;
   logic [7:0]            gap_q;
   logic [7:0]            op_q;
   logic [23:0]           dest_qp_q;
   logic [23:0]           psn_q;
   logic [31:0]           frames_q;
   logic [15:0]           beat_q;
   logic [15:0]           last_beat_q;
   logic [KEEP_WIDTH-1:0] last_keep_q;
   logic [7:0]            gap_cnt_q;
   logic                  stop_seen_q;
   logic                  done_q;
   logic                  bth_valid_q;
   logic                  tvalid_q;
   logic                  tlast_q;
   logic [KEEP_WIDTH-1:0] tkeep_q;

   logic [15:0]           cfg_last_beat;
   logic [KW_LOG2-1:0]    cfg_rem;
   logic [KEEP_WIDTH-1:0] cfg_last_keep;
   logic [15:0]           next_beat;
   logic [31:0]           frames_next;
   logic                  frame_end;
   logic                  end_run;
   logic [31:0]           byte_off;
   logic [31:0]           lfsr_state;

   // Index of the final beat, floor((len-1)/KW); only used when len > 0.
   assign cfg_last_beat = (cfg_payload_len - 16'd1) >> KW_LOG2;
   assign cfg_rem       = cfg_payload_len[KW_LOG2-1:0];
   assign cfg_last_keep = (cfg_rem == '0) ? {KEEP_WIDTH{1'b1}}
                                          : ~({KEEP_WIDTH{1'b1}} << cfg_rem);

   assign next_beat   = beat_q + 16'd1;
   assign frames_next = frames_q + 32'd1;

   // A frame ends on the header handshake of an empty frame or on accepted tlast.
   assign frame_end = (state_q == ST_HDR && bth_valid_q && m_roce_bth_ready && len_q == 16'd0)
                   || (state_q == ST_PAYLOAD && tvalid_q && m_axis_tready && tlast_q);
   // A stop arriving in the same cycle as the frame end still counts.
   assign end_run   = ((count_q != 32'd0) && (frames_next == count_q)) || stop_seen_q || stop;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         count_q     <= '0;
         gap_q       <= '0;
         op_q        <= '0;
         dest_qp_q   <= '0;
         psn_q       <= '0;
         frames_q    <= '0;
         beat_q      <= '0;
         last_beat_q <= '0;
         last_keep_q <= '0;
         gap_cnt_q   <= '0;
         stop_seen_q <= 1'b0;
         done_q      <= 1'b0;
         bth_valid_q <= 1'b0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tkeep_q     <= '0;
      end else begin
         done_q <= 1'b0;
         if (state_q != ST_IDLE && stop) begin
            stop_seen_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  len_q       <= cfg_payload_len;
                  count_q     <= cfg_frame_count;
                  gap_q       <= cfg_gap_cycles;
                  op_q        <= cfg_op_code;
                  dest_qp_q   <= cfg_dest_qp;
                  psn_q       <= cfg_psn_start;
                  last_beat_q <= cfg_last_beat;
                  last_keep_q <= cfg_last_keep;
                  frames_q    <= '0;
                  stop_seen_q <= 1'b0;
                  bth_valid_q <= 1'b1;
                  state_q     <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (m_roce_bth_ready) begin
                  bth_valid_q <= 1'b0;
                  if (len_q != 16'd0) begin
                     state_q  <= ST_PAYLOAD;
                     tvalid_q <= 1'b1;
                     beat_q   <= '0;
                     tlast_q  <= (last_beat_q == 16'd0);
                     tkeep_q  <= (last_beat_q == 16'd0) ? last_keep_q : {KEEP_WIDTH{1'b1}};
                  end
               end
            end
            ST_PAYLOAD: begin
               if (m_axis_tready && !tlast_q) begin
                  beat_q  <= next_beat;
                  tlast_q <= (next_beat == last_beat_q);
                  tkeep_q <= (next_beat == last_beat_q) ? last_keep_q : {KEEP_WIDTH{1'b1}};
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == 8'd1) begin
                  bth_valid_q <= 1'b1;
                  state_q     <= ST_HDR;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         // Frame completion overrides the per-state updates above.
         if (frame_end) begin
            psn_q    <= psn_q + 24'd1;
            frames_q <= frames_next;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tkeep_q  <= '0;
            if (end_run) begin
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end else if (gap_q == 8'd0) begin
               bth_valid_q <= 1'b1;
               state_q     <= ST_HDR;
            end else begin
               gap_cnt_q <= gap_q;
               state_q   <= ST_GAP;
            end
         end
      end
   end

   roce_lfsr32 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .en_i    (tvalid_q && m_axis_tready),
      .state_o (lfsr_state)
   );

   assign byte_off = {16'd0, beat_q} << KW_LOG2;

   // Lane 0 carries the byte offset, higher lanes the LFSR pattern; zero when idle.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         if (gi == 0) begin : g_off
            assign m_axis_tdata[31:0] = tvalid_q ? byte_off : 32'd0;
         end else begin : g_pat
            assign m_axis_tdata[gi*32 +: 32] = tvalid_q ? (lfsr_state ^ 32'(gi)) : 32'd0;
         end
      end
   endgenerate

   assign m_roce_bth_valid   = bth_valid_q;
   assign m_roce_bth_op_code = op_q;
   assign m_roce_bth_psn     = psn_q;
   assign m_roce_bth_dest_qp = dest_qp_q;
   assign m_roce_bth_ack_req = bth_valid_q && (count_q != 32'd0) && (frames_next == count_q);
   assign m_axis_tkeep       = tkeep_q;
   assign m_axis_tvalid      = tvalid_q;
   assign m_axis_tlast       = tlast_q;
   assign m_axis_tuser       = 1'b0;
   assign busy               = (state_q != ST_IDLE);
   assign done               = done_q;
   assign frames_sent        = frames_q;

endmodule

// File: tb/tb_roce_payload_gen.sv
module tb_roce_payload_gen;

   localparam logic [31:0] SEED = 32'hACE1_2468;

   logic        clk, resetn, start, start2, stop;
   logic [15:0] cfg_payload_len;
   logic [31:0] cfg_frame_count;
   logic [7:0]  cfg_gap_cycles, cfg_op_code;
   logic [23:0] cfg_psn_start, cfg_dest_qp;
   logic        bth_ready, tready;

   logic        bth_valid, bth_ack;
   logic [7:0]  bth_op;
   logic [23:0] bth_psn, bth_qp;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid, tlast, tuser, busy, done;
   logic [31:0] frames;

   logic         b2_valid, b2_ack;
   logic [7:0]   b2_op;
   logic [23:0]  b2_psn, b2_qp;
   logic [511:0] b2_tdata;
   logic [63:0]  b2_tkeep;
   logic         b2_tvalid, b2_tlast, b2_tuser, b2_busy, b2_done;
   logic [31:0]  b2_frames;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] lfsr_m, lfsr2_m;
   logic [7:0]  exp_op;
   logic [23:0] exp_qp;

   roce_payload_gen #(.DATA_WIDTH(64)) dut (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop),
      .cfg_payload_len(cfg_payload_len), .cfg_frame_count(cfg_frame_count),
      .cfg_gap_cycles(cfg_gap_cycles), .cfg_op_code(cfg_op_code),
      .cfg_psn_start(cfg_psn_start), .cfg_dest_qp(cfg_dest_qp),
      .m_roce_bth_valid(bth_valid), .m_roce_bth_ready(bth_ready),
      .m_roce_bth_op_code(bth_op), .m_roce_bth_psn(bth_psn),
      .m_roce_bth_dest_qp(bth_qp), .m_roce_bth_ack_req(bth_ack),
      .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
      .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
      .busy(busy), .done(done), .frames_sent(frames)
   );

   roce_payload_gen #(.DATA_WIDTH(512)) dut_w (
      .clk(clk), .resetn(resetn), .start(start2), .stop(1'b0),
      .cfg_payload_len(cfg_payload_len), .cfg_frame_count(cfg_frame_count),
      .cfg_gap_cycles(cfg_gap_cycles), .cfg_op_code(cfg_op_code),
      .cfg_psn_start(cfg_psn_start), .cfg_dest_qp(cfg_dest_qp),
      .m_roce_bth_valid(b2_valid), .m_roce_bth_ready(bth_ready),
      .m_roce_bth_op_code(b2_op), .m_roce_bth_psn(b2_psn),
      .m_roce_bth_dest_qp(b2_qp), .m_roce_bth_ack_req(b2_ack),
      .m_axis_tdata(b2_tdata), .m_axis_tkeep(b2_tkeep), .m_axis_tvalid(b2_tvalid),
      .m_axis_tready(tready), .m_axis_tlast(b2_tlast), .m_axis_tuser(b2_tuser),
      .busy(b2_busy), .done(b2_done), .frames_sent(b2_frames)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference LFSR written straight from taps 32,22,2,1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Header then nbeats payload beats with tready=1; returns on the cycle after tlast.
   task automatic expect_frame(input logic [23:0] psn, input logic ack, input int nbeats,
                               input logic [7:0] lkeep, input int stop_beat);
      int w = 0;
      while (bth_valid !== 1'b1 && w < 40) begin
         chk("wait_no_tvalid", tvalid, 0);
         @(negedge clk);
         w++;
      end
      chk("hdr_valid", bth_valid, 1);
      chk("hdr_psn", bth_psn, psn);
      chk("hdr_ack", bth_ack, ack);
      chk("hdr_op", bth_op, exp_op);
      chk("hdr_qp", bth_qp, exp_qp);
      chk("hdr_no_tvalid", tvalid, 0);
      @(negedge clk);
      chk("hdr_dropped", bth_valid, 0);
      for (int b = 0; b < nbeats; b++) begin
         stop = (b == stop_beat);
         chk("beat_valid", tvalid, 1);
         chk("beat_off", tdata[31:0], b * 8);
         chk("beat_lane1", tdata[63:32], lfsr_m ^ 32'd1);
         chk("beat_keep", tkeep, (b == nbeats - 1) ? lkeep : 8'hFF);
         chk("beat_last", tlast, (b == nbeats - 1) ? 1 : 0);
         lfsr_m = lfsr_next(lfsr_m);
         @(negedge clk);
      end
      stop = 1'b0;
   endtask

   initial begin
      logic [3:0] pat;
      int b, c;
      resetn = 1'b0; start = 1'b0; start2 = 1'b0; stop = 1'b0;
      cfg_payload_len = '0; cfg_frame_count = '0; cfg_gap_cycles = '0;
      cfg_op_code = '0; cfg_psn_start = '0; cfg_dest_qp = '0;
      bth_ready = 1'b1; tready = 1'b1;
      lfsr_m = SEED; lfsr2_m = SEED;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_bth_valid", bth_valid, 0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_frames", frames, 0);
      chk("rst_psn", bth_psn, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tkeep", tkeep, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tuser", tuser, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Wide bus: 128 bytes on 64-byte beats
      cfg_payload_len = 16'd128; cfg_frame_count = 32'd1; cfg_gap_cycles = 8'd0;
      cfg_psn_start = 24'd5; cfg_op_code = 8'h2A; cfg_dest_qp = 24'd1;
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      chk("w_hdr_valid", b2_valid, 1);
      chk("w_hdr_psn", b2_psn, 24'd5);
      @(negedge clk);
      chk("w_b0_valid", b2_tvalid, 1);
      chk("w_b0_keep", b2_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("w_b0_off", b2_tdata[31:0], 0);
      chk("w_b0_last", b2_tlast, 0);
      chk("w_b0_lane1", b2_tdata[63:32], lfsr2_m ^ 32'd1);
      chk("w_b0_lane15", b2_tdata[511:480], lfsr2_m ^ 32'd15);
      lfsr2_m = lfsr_next(lfsr2_m);
      @(negedge clk);
      chk("w_b1_valid", b2_tvalid, 1);
      chk("w_b1_keep", b2_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("w_b1_off", b2_tdata[31:0], 64);
      chk("w_b1_last", b2_tlast, 1);
      chk("w_b1_lane15", b2_tdata[511:480], lfsr2_m ^ 32'd15);
      lfsr2_m = lfsr_next(lfsr2_m);
      @(negedge clk);
      chk("w_end_tvalid", b2_tvalid, 0);
      chk("w_end_done", b2_done, 1);
      chk("w_end_frames", b2_frames, 1);
      chk("w_end_busy", b2_busy, 0);
      chk("w_narrow_idle", busy, 0);

      // Two 92-byte frames, gap 3; cfg changes and a start during the run are ignored
      cfg_payload_len = 16'd92; cfg_frame_count = 32'd2; cfg_gap_cycles = 8'd3;
      cfg_psn_start = 24'd200; cfg_op_code = 8'h0A; cfg_dest_qp = 24'h123456;
      exp_op = 8'h0A; exp_qp = 24'h123456;
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("r1_busy", busy, 1);
      chk("r1_hdr_latency", bth_valid, 1);
      cfg_payload_len = 16'd16; cfg_psn_start = 24'd500; cfg_frame_count = 32'd7;
      cfg_op_code = 8'h55; cfg_gap_cycles = 8'd0;
      expect_frame(24'd200, 1'b0, 12, 8'h0F, -1);
      for (int i = 0; i < 3; i++) begin
         chk("r1_gap_bth", bth_valid, 0);
         chk("r1_gap_tvalid", tvalid, 0);
         chk("r1_gap_busy", busy, 1);
         start = (i == 1);
         @(negedge clk);
      end
      start = 1'b0;
      chk("r1_gap_exact", bth_valid, 1);
      expect_frame(24'd201, 1'b1, 12, 8'h0F, -1);
      chk("r1_done", done, 1);
      chk("r1_frames", frames, 2);
      chk("r1_busy_end", busy, 0);
      chk("r1_no_hdr3", bth_valid, 0);
      @(negedge clk);
      chk("r1_done_pulse", done, 0);

      // Backpressure 1,0,0,1 on a 4-beat frame, PSN wraps into frame 2
      cfg_payload_len = 16'd32; cfg_frame_count = 32'd2; cfg_gap_cycles = 8'd0;
      cfg_psn_start = 24'hFFFFFF; cfg_op_code = 8'h0A;
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("s_hdr_valid", bth_valid, 1);
      chk("s_hdr_psn", bth_psn, 24'hFFFFFF);
      chk("s_hdr_ack", bth_ack, 0);
      @(negedge clk);
      pat = 4'b1001;
      b = 0; c = 0;
      while (b < 4 && c < 40) begin
         chk("s_valid", tvalid, 1);
         chk("s_off", tdata[31:0], b * 8);
         chk("s_lane1", tdata[63:32], lfsr_m ^ 32'd1);
         chk("s_last", tlast, (b == 3) ? 1 : 0);
         tready = pat[c % 4];
         if (tready) begin
            b++;
            lfsr_m = lfsr_next(lfsr_m);
         end
         c++;
         @(negedge clk);
      end
      tready = 1'b1;
      chk("s_beats", b, 4);
      chk("s_cycles", c, 8);
      chk("s_hdr2_nogap", bth_valid, 1);
      expect_frame(24'd0, 1'b1, 4, 8'hFF, -1);
      chk("s_done", done, 1);
      chk("s_frames", frames, 2);

      // Zero-length frames back to back
      cfg_payload_len = 16'd0; cfg_frame_count = 32'd3; cfg_gap_cycles = 8'd0;
      cfg_psn_start = 24'd10;
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("z_hdr_valid", bth_valid, 1);
         chk("z_hdr_psn", bth_psn, 10 + i);
         chk("z_hdr_ack", bth_ack, (i == 2) ? 1 : 0);
         chk("z_tvalid", tvalid, 0);
         chk("z_frames", frames, i);
         @(negedge clk);
      end
      chk("z_end_bth", bth_valid, 0);
      chk("z_end_done", done, 1);
      chk("z_end_frames", frames, 3);
      chk("z_end_busy", busy, 0);
      chk("z_end_tvalid", tvalid, 0);

      // Unbounded run stopped during frame 5
      cfg_payload_len = 16'd16; cfg_frame_count = 32'd0; cfg_gap_cycles = 8'd1;
      cfg_psn_start = 24'd100;
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int f = 0; f < 5; f++) begin
         expect_frame(24'(100 + f), 1'b0, 2, 8'hFF, (f == 4) ? 0 : -1);
      end
      chk("u_done", done, 1);
      chk("u_frames", frames, 5);
      chk("u_busy", busy, 0);
      for (int i = 0; i < 5; i++) begin
         chk("u_no_hdr6", bth_valid, 0);
         @(negedge clk);
      end

      // Reset in the middle of a payload, then a clean restart
      cfg_payload_len = 16'd92; cfg_frame_count = 32'd1; cfg_gap_cycles = 8'd0;
      cfg_psn_start = 24'd77;
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("x_hdr_psn", bth_psn, 24'd77);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("x_pre_valid", tvalid, 1);
         @(negedge clk);
      end
      resetn = 1'b0;
      @(negedge clk);
      chk("x_tvalid", tvalid, 0);
      chk("x_busy", busy, 0);
      chk("x_bth", bth_valid, 0);
      chk("x_frames", frames, 0);
      chk("x_tdata", tdata, 0);
      chk("x_tkeep", tkeep, 0);
      chk("x_tlast", tlast, 0);
      chk("x_psn", bth_psn, 0);
      resetn = 1'b1;
      lfsr_m = SEED; lfsr2_m = SEED;
      @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      expect_frame(24'd77, 1'b1, 12, 8'h0F, -1);
      chk("x_done", done, 1);
      chk("x_frames_end", frames, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/roce_payload_gen.md
ROCE_PAYLOAD_GEN -- requirements
Module: roce_payload_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload bus width in bits; legal values 64, 128, 256, 512.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter LFSR_SEED, default 32'hACE1_2468, non-zero reset state of the pattern LFSR.
REQ-004 SHALL have ports clk (in, 1, sole clock) and resetn (in, 1); one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports start (in, 1, start pulse), stop (in, 1, graceful stop request), cfg_payload_len (in, 16, payload bytes per frame), cfg_frame_count (in, 32, frames per run, 0 = unbounded), cfg_gap_cycles (in, 8, idle cycles between frames), cfg_op_code (in, 8), cfg_psn_start (in, 24), cfg_dest_qp (in, 24).
REQ-006 SHALL have header ports m_roce_bth_valid (out, 1), m_roce_bth_ready (in, 1), m_roce_bth_op_code (out, 8), m_roce_bth_psn (out, 24), m_roce_bth_dest_qp (out, 24), m_roce_bth_ack_req (out, 1).
REQ-007 SHALL have payload ports m_axis_tdata (out, DATA_WIDTH), m_axis_tkeep (out, KEEP_WIDTH), m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tlast (out, 1), m_axis_tuser (out, 1, tied 0).
REQ-008 SHALL have status ports busy (out, 1), done (out, 1, one-cycle pulse at run end), frames_sent (out, 32).

Function
REQ-009 SHALL implement states IDLE, HDR, PAYLOAD, GAP.
REQ-010 IDLE: start=1 SHALL latch all cfg_* inputs, load PSN with cfg_psn_start, clear frames_sent, enter HDR next cycle; cfg changes afterwards SHALL have no effect until the next start.
REQ-011 start while busy SHALL be ignored.
REQ-012 HDR: m_roce_bth_valid SHALL be 1 with stable fields until m_roce_bth_ready=1; on handshake go to PAYLOAD, or directly to GAP/end if latched length is 0.
REQ-013 m_roce_bth_ack_req SHALL be 1 only on the last frame of a bounded run.
REQ-014 No payload beat SHALL be valid before the frame's header handshake completes.
REQ-015 PAYLOAD: beats = ceil(len/KEEP_WIDTH); tlast on final beat; tkeep all-ones except final beat = low (len mod KEEP_WIDTH) bits set, all-ones when remainder is 0.
REQ-016 tdata[31:0] SHALL equal byte offset of the beat within the frame (0, KEEP_WIDTH, 2*KEEP_WIDTH, ...); every higher 32-bit lane k SHALL equal LFSR state XOR k.
REQ-017 LFSR (32-bit, taps 32,22,2,1) SHALL advance once per accepted beat only.
REQ-018 tdata/tkeep/tlast SHALL be held stable while tvalid=1 and tready=0; tvalid SHALL not drop before acceptance.
REQ-019 On accepted tlast (or header handshake for zero-length frame): PSN SHALL increment modulo 2^24, frames_sent increments.
REQ-020 Run SHALL end after frames_sent reaches cfg_frame_count (non-zero), or at frame end if stop was seen during the run; end SHALL pulse done, return to IDLE, drop busy.
REQ-021 stop SHALL never truncate a frame in progress; stop in IDLE SHALL be ignored.
REQ-022 GAP: wait exactly cfg_gap_cycles cycles with all valids low, then HDR; gap 0 SHALL go straight to HDR with no idle cycle.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Latency: start at cycle N SHALL give m_roce_bth_valid=1 at N+1; header handshake at M SHALL give first tvalid at M+1.

Reset
REQ-025 resetn=0 at a clock edge SHALL force IDLE, all valids 0, busy 0, done 0, frames_sent 0, PSN 0, LFSR to LFSR_SEED, tdata/tkeep/tlast 0, from the following cycle, including mid-frame.

Structure
REQ-026 State encoding and LFSR tap constant SHALL live in shared package roce_gen_pkg.
REQ-027 LFSR SHALL be a sub-module roce_lfsr32 (enable, state out).
REQ-028 Counters: beat counter 16 bits, gap counter 8 bits, frame counter 32 bits, no wrap on frames_sent in bounded runs.

Verification
REQ-029 DATA_WIDTH=64, len=92, count=2, gap=3, tready=1: 12 beats/frame, last tkeep 8'h0F, PSN 200->201, ack_req on frame 2 only, done after 2nd tlast.
REQ-030 DATA_WIDTH=512, len=128, count=1: exactly 2 beats, tkeep all-ones both, tdata[31:0]=0 then 64.
REQ-031 tready toggling 1,0,0,1 pattern: no data change while stalled, LFSR advances only on accepted beats.
REQ-032 len=0, count=3, gap=0: three back-to-back header handshakes, no tvalid, frames_sent=3.
REQ-033 count=0 with stop asserted mid-frame 5: frame 5 completes with tlast, done pulses, no header 6.
REQ-034 resetn=0 mid-payload: next cycle tvalid=0, busy=0, state IDLE; subsequent start restarts from cfg_psn_start.
